// File: rtl/classify_sequencer.sv
// classify_sequencer
//
// Owns the class-score buffer of the output layer and feeds it, one score per
// cycle, into the downstream argmax comparator. After the last beat it waits
// a bounded number of cycles for the comparator decision. It then reports
// either a one-cycle result pulse or a one-cycle timeout error.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en/addr/data     score buffer write port (accepted only while idle)
//   start               request one classification frame
//   hold                stall the stream; the beat at the next edge is skipped
//   busy                controller not idle (registered next-state view)
//   cmp_valid/cmp_data  score beat to the comparator
//   cmp_decision        comparator decision index
//   cmp_valid_out       comparator decision strobe (used only while waiting)
//   result/result_valid accepted class index and its one-cycle update pulse
//   err                 one-cycle pulse when the comparator fails to answer

module classify_sequencer #(
    parameter int unsigned NUM_CLASSES = 10,
    parameter int unsigned DATA_W      = 12,
    parameter int unsigned TIMEOUT     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [3:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic              hold,
    output logic              busy,
    output logic              cmp_valid,
    output logic [DATA_W-1:0] cmp_data,
    input  logic [3:0]        cmp_decision,
    input  logic              cmp_valid_out,
    output logic [3:0]        result,
    output logic              result_valid,
    output logic              err
);

    localparam logic [3:0] NumEntries = 4'(NUM_CLASSES);
    localparam logic [3:0] LastIdx    = 4'(NUM_CLASSES - 1);
    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StWait
    } state_t;

    state_t            state;
    logic [3:0]        idx;
    logic [7:0]        tcount;
    logic [DATA_W-1:0] scores [NUM_CLASSES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StIdle;
            idx          <= '0;
            tcount       <= '0;
            busy         <= 1'b0;
            cmp_valid    <= 1'b0;
            cmp_data     <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            err          <= 1'b0;
            for (int i = 0; i < NUM_CLASSES; i++) begin
                scores[i] <= '0;
            end
        end else begin
            // Pulses default low; set only on the edge that ends a frame.
            result_valid <= 1'b0;
            err          <= 1'b0;

            unique case (state)
                StIdle: begin
                    cmp_valid <= 1'b0;
                    if (start) begin
                        // A write coinciding with an accepted start is dropped.
                        state <= StStream;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end else if (wr_en && (wr_addr < NumEntries)) begin
                        scores[wr_addr] <= wr_data;
                    end
                end

                StStream: begin
                    if (hold) begin
                        cmp_valid <= 1'b0;
                    end else begin
                        cmp_valid <= 1'b1;
                        cmp_data  <= scores[idx];
                        if (idx == LastIdx) begin
                            state <= StWait;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end

                StWait: begin
                    cmp_valid <= 1'b0;
                    // A decision arriving on the final timeout edge still wins.
                    if (cmp_valid_out) begin
                        result       <= cmp_decision;
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        tcount       <= '0;
                        state        <= StIdle;
                    end else if (tcount == TimeoutCnt) begin
                        err    <= 1'b1;
                        busy   <= 1'b0;
                        tcount <= '0;
                        state  <= StIdle;
                    end else begin
                        tcount <= tcount + 8'd1;
                    end
                end

                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_classify_sequencer.sv
module tb_classify_sequencer;

    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [11:0] wr_data = '0;
    logic        start = 1'b0;
    logic        hold = 1'b0;
    logic        busy;
    logic        cmp_valid;
    logic [11:0] cmp_data;
    logic [3:0]  cmp_decision;
    logic        cmp_valid_out;
    logic [3:0]  result;
    logic        result_valid;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [11:0] model [10];
    logic [3:0]  exp_result_last = '0;

    // Comparator model controls
    bit cmp_respond = 1'b1;
    bit inject_vo = 1'b0;

    always #5 clk = ~clk;

    classify_sequencer #(
        .NUM_CLASSES(10),
        .DATA_W     (12),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .start        (start),
        .hold         (hold),
        .busy         (busy),
        .cmp_valid    (cmp_valid),
        .cmp_data     (cmp_data),
        .cmp_decision (cmp_decision),
        .cmp_valid_out(cmp_valid_out),
        .result       (result),
        .result_valid (result_valid),
        .err          (err)
    );

    // Behavioural comparator: counts 10-beat frames, answers first-max index
    // one cycle after the last beat.
    int          ccnt;
    logic [11:0] cbest;
    logic [3:0]  cidx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ccnt          <= 0;
            cbest         <= '0;
            cidx          <= '0;
            cmp_valid_out <= 1'b0;
            cmp_decision  <= '0;
        end else begin
            cmp_valid_out <= inject_vo;
            if (inject_vo) cmp_decision <= 4'd7;
            if (cmp_valid) begin
                if (ccnt == 0 || cmp_data > cbest) begin
                    cbest <= cmp_data;
                    cidx  <= 4'(ccnt);
                end
                if (ccnt == 9) begin
                    ccnt <= 0;
                    if (cmp_respond) begin
                        cmp_valid_out <= 1'b1;
                        cmp_decision  <= (cmp_data > cbest) ? 4'd9 : cidx;
                    end
                end else begin
                    ccnt <= ccnt + 1;
                end
            end
        end
    end

    function automatic logic [3:0] argmax_model();
        logic [3:0]  bi = 4'd0;
        logic [11:0] bv = model[0];
        for (int i = 1; i < 10; i++) begin
            if (model[i] > bv) begin
                bv = model[i];
                bi = 4'(i);
            end
        end
        return bi;
    endfunction

    task automatic write_score(input logic [3:0] a, input logic [11:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (a < 4'd10) model[a] = d;
    endtask

    task automatic load_plan();
        logic [11:0] vals [10];
        vals = '{12'd100, 12'd200, 12'd50, 12'd900, 12'd3,
                 12'd0, 12'd899, 12'd10, 12'd11, 12'd12};
        for (int i = 0; i < 10; i++) write_score(4'(i), vals[i]);
    endtask

    // Runs one frame starting at the current negedge. Cycle c is the period
    // after edge c, where edge 0 samples start. hmask bit e = hold at edge e.
    task automatic run_frame(input bit [63:0] hmask, input bit respond,
                             input bit keep_start, input bit mid_write,
                             input bit start_write);
        bit          expv [64];
        logic [11:0] expd [64];
        int          k, last_edge, end_c;
        logic [3:0]  exp_res;
        for (int e = 0; e < 64; e++) begin
            expv[e] = 1'b0;
            expd[e] = '0;
        end
        k = 0;
        last_edge = 0;
        for (int e = 1; e < 64 && k < 10; e++) begin
            if (!hmask[e]) begin
                expv[e] = 1'b1;
                expd[e] = model[k];
                k++;
                last_edge = e;
            end
        end
        end_c   = respond ? last_edge + 2 : last_edge + TIMEOUT + 1;
        exp_res = respond ? argmax_model() : exp_result_last;
        cmp_respond = respond;

        start = 1'b1;
        hold  = 1'b0;
        if (start_write) begin
            wr_en   = 1'b1;
            wr_addr = 4'd0;
            wr_data = ~model[0];
        end
        @(negedge clk);
        for (int c = 0; c <= end_c; c++) begin
            if (c > 0) @(negedge clk);
            if (c >= 1) begin
                n_checks++;
                if (cmp_valid !== expv[c]) begin
                    n_errors++;
                    $display("FAIL cmp_valid: cycle %0d got %b expected %b", c, cmp_valid, expv[c]);
                end
                if (expv[c]) begin
                    n_checks++;
                    if (cmp_data !== expd[c]) begin
                        n_errors++;
                        $display("FAIL cmp_data: cycle %0d got %0d expected %0d",
                                 c, cmp_data, expd[c]);
                    end
                end
                n_checks++;
                if (busy !== (c < end_c)) begin
                    n_errors++;
                    $display("FAIL busy: cycle %0d got %b expected %b", c, busy, (c < end_c));
                end
                n_checks++;
                if (result_valid !== (c == end_c && respond)) begin
                    n_errors++;
                    $display("FAIL result_valid: cycle %0d got %b expected %b",
                             c, result_valid, (c == end_c && respond));
                end
                n_checks++;
                if (err !== (c == end_c && !respond)) begin
                    n_errors++;
                    $display("FAIL err: cycle %0d got %b expected %b",
                             c, err, (c == end_c && !respond));
                end
            end
            if (c == end_c) begin
                n_checks++;
                if (result !== exp_res) begin
                    n_errors++;
                    $display("FAIL result: cycle %0d got %0d expected %0d", c, result, exp_res);
                end
            end
            start   = keep_start;
            hold    = (c + 1 < 64) ? hmask[c+1] : 1'b0;
            wr_en   = mid_write && (c >= 1) && (c < end_c);
            wr_addr = 4'd2;
            wr_data = 12'hfff;
        end
        wr_en = 1'b0;
        hold  = 1'b0;
        exp_result_last = exp_res;
    endtask

    task automatic check_outputs_zero(input string name);
        n_checks++;
        if ({busy, cmp_valid, cmp_data, result, result_valid, err} !== '0) begin
            n_errors++;
            $display("FAIL %s: got busy=%b cmp_valid=%b cmp_data=%0d result=%0d rv=%b err=%b expected all 0",
                     name, busy, cmp_valid, cmp_data, result, result_valid, err);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 10; i++) model[i] = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("after_release");
    endtask

    task automatic test_basic();
        load_plan();
        run_frame(64'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_hold();
        bit [63:0] m = '0;
        m[3] = 1'b1;
        m[4] = 1'b1;
        run_frame(m, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_timeout();
        run_frame(64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_after: got busy=%b err=%b expected 0 0", busy, err);
        end
        run_frame(64'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_write_ignore();
        write_score(4'd12, 12'd4095);
        run_frame(64'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        run_frame(64'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        run_frame(64'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_idle_response();
        inject_vo = 1'b1;
        @(negedge clk);
        inject_vo = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (result_valid !== 1'b0 || err !== 1'b0 || busy !== 1'b0 ||
                result !== exp_result_last) begin
                n_errors++;
                $display("FAIL idle_response: got rv=%b err=%b busy=%b result=%0d expected 0 0 0 %0d",
                         result_valid, err, busy, result, exp_result_last);
            end
        end
    endtask

    task automatic test_back_to_back();
        model[5] = 12'd950;
        write_score(4'd5, 12'd950);
        run_frame(64'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        run_frame(64'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        run_frame(64'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("reset_mid");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) model[i] = '0;
        exp_result_last = '0;
        @(negedge clk);
        run_frame(64'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        load_plan();
        run_frame(64'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            bit [63:0] m = '0;
            int nw = $urandom_range(1, 12);
            for (int w = 0; w < nw; w++) begin
                write_score(4'($urandom_range(0, 15)), 12'($urandom_range(0, 4095)));
            end
            for (int e = 1; e < 25; e++) m[e] = ($urandom_range(0, 3) == 0);
            run_frame(m, ($urandom_range(0, 4) != 0), 1'b0, ($urandom_range(0, 1) == 1), 1'b0);
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_timeout();
        test_write_ignore();
        test_idle_response();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
